// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the pipelined immediate generator.
// Upstream entry, flush and downstream ready/result in one interface.
interface imm_gen_pipe_if #(
  parameter int Width = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       ImmSrc;
  logic [Width-1:0] pc;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] ImmOp;
  logic [Width-1:0] target;
  logic             imm_err;

  modport master (
    output flush, in_valid, instr,
    output ImmSrc, pc, out_ready,
    input  in_ready, out_valid,
    input  ImmOp, target, imm_err
  );

  modport slave (
    input  flush, in_valid, instr,
    input  ImmSrc, pc, out_ready,
    output in_ready, out_valid,
    output ImmOp, target, imm_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate extractor with PC-relative target,
// followed by Depth elastic valid/ready register stages.
module imm_gen_pipe #(
  parameter int Width = 32,
  parameter int Depth = 2
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [Width-1:0] imm;
    logic [Width-1:0] tgt;
    logic             err;
  } ent_t;

  logic signed [31:0] w_i32;
  logic               w_err;
  logic [Width-1:0]   w_imm;
  ent_t               w_ent;
  logic               w_s;
  logic               w_unused;

  logic [Depth-1:0]   r_v;
  ent_t               r_ent [Depth];
  logic [Depth-1:0]   w_rdy;
  logic [Depth-1:0]   w_up;
  logic [Depth-1:0]   w_xfer;

  assign w_s      = bus.instr[31];
  assign w_unused = ^bus.instr[6:0];

  always_comb begin
    w_i32 = '0;
    w_err = 1'b0;
    unique case (bus.ImmSrc)
      3'b000: w_i32 = {{20{w_s}}, bus.instr[31:20]};
      3'b001: w_i32 = {{20{w_s}}, bus.instr[31:25],
                       bus.instr[11:7]};
      3'b010: w_i32 = {{19{w_s}}, w_s, bus.instr[7],
                       bus.instr[30:25],
                       bus.instr[11:8], 1'b0};
      3'b011: w_i32 = '0;
      3'b100: w_i32 = {bus.instr[31:12], 12'b0};
      3'b101: w_i32 = {{11{w_s}}, w_s,
                       bus.instr[19:12], bus.instr[20],
                       bus.instr[30:21], 1'b0};
      3'b110: w_i32 = {27'b0, bus.instr[19:15]};
      3'b111: w_err = 1'b1;
    endcase
  end

  // Every format is a signed 32-bit value; Z-type is
  // non-negative, so one sign extension covers RV64 too.
  assign w_imm     = Width'(w_i32);
  assign w_ent.imm = w_imm;
  assign w_ent.tgt = bus.pc + w_imm;
  assign w_ent.err = w_err;

  always_comb begin
    logic acc;
    acc = !r_v[Depth-1] || bus.out_ready;
    w_rdy[Depth-1] = acc;
    for (int i = Depth - 2; i >= 0; i--) begin
      acc      = !r_v[i] || acc;
      w_rdy[i] = acc;
    end
  end

  assign bus.in_ready = w_rdy[0] && !bus.flush;

  always_comb begin
    w_up[0] = bus.in_valid && bus.in_ready;
    for (int i = 1; i < Depth; i++)
      w_up[i] = r_v[i-1];
  end

  assign w_xfer = w_up & w_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < Depth; i++)
        r_ent[i] <= '0;
    end else begin
      if (w_xfer[0])
        r_ent[0] <= w_ent;
      for (int i = 1; i < Depth; i++)
        if (w_xfer[i])
          r_ent[i] <= r_ent[i-1];
      if (bus.flush)
        r_v <= '0;
      else
        r_v <= w_xfer | (r_v & ~w_rdy);
    end
  end

  assign bus.out_valid = r_v[Depth-1];
  assign bus.ImmOp     = r_ent[Depth-1].imm;
  assign bus.target    = r_ent[Depth-1].tgt;
  assign bus.imm_err   = r_ent[Depth-1].err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 Depth=2 and RV64 Depth=1
// instances against a field-arithmetic model plus literals.
module tb_imm_gen_pipe;
  localparam int D   = 2;
  localparam int D64 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.Width(32)) b32 ();
  imm_gen_pipe_if #(.Width(64)) b64 ();

  imm_gen_pipe #(.Width(32), .Depth(D)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.slave)
  );
  imm_gen_pipe #(.Width(64), .Depth(D64)) dut64 (
    .clk(clk), .rst(rst), .bus(b64.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        err;
  } exp_t;

  exp_t q32 [$];
  exp_t q64 [$];

  function automatic void chk(string nm,
                              logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endfunction

  // Immediate value as a signed number built from fields
  function automatic logic [63:0] ref_imm(
    input logic [31:0] ins, input logic [2:0] src);
    longint x;
    x = longint'($signed(ins));
    case (src)
      3'd0: return x >>> 20;
      3'd1: return ((x >>> 25) <<< 5)
                 | longint'(ins[11:7]);
      3'd2: return ((x >>> 31) <<< 12)
                 | (longint'(ins[7]) << 11)
                 | (longint'(ins[30:25]) << 5)
                 | (longint'(ins[11:8]) << 1);
      3'd4: return (x >>> 12) <<< 12;
      3'd5: return ((x >>> 31) <<< 20)
                 | (longint'(ins[19:12]) << 12)
                 | (longint'(ins[20]) << 11)
                 | (longint'(ins[30:21]) << 1);
      3'd6: return longint'(ins[19:15]);
      default: return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [63:0] m;
    exp_t e;
    if (rst) begin
      q32.delete();
      q64.delete();
    end else begin
      if (b32.out_valid) begin
        if (q32.size() == 0)
          chk("stale32", 64'(b32.out_valid), 64'd0);
        else begin
          chk("m_imm32", 64'(b32.ImmOp), q32[0].imm);
          chk("m_tgt32", 64'(b32.target), q32[0].tgt);
          chk("m_err32", 64'(b32.imm_err),
              64'(q32[0].err));
        end
      end
      if (b32.flush)
        q32.delete();
      else begin
        if (b32.out_valid && b32.out_ready
            && q32.size() > 0)
          void'(q32.pop_front());
        if (b32.in_valid && b32.in_ready) begin
          m     = ref_imm(b32.instr, b32.ImmSrc);
          e.imm = {32'd0, m[31:0]};
          e.tgt = {32'd0, b32.pc + m[31:0]};
          e.err = (b32.ImmSrc == 3'b111);
          q32.push_back(e);
        end
      end
      if (b64.out_valid) begin
        if (q64.size() == 0)
          chk("stale64", 64'(b64.out_valid), 64'd0);
        else begin
          chk("m_imm64", b64.ImmOp, q64[0].imm);
          chk("m_tgt64", b64.target, q64[0].tgt);
          chk("m_err64", 64'(b64.imm_err),
              64'(q64[0].err));
        end
      end
      if (b64.flush)
        q64.delete();
      else begin
        if (b64.out_valid && b64.out_ready
            && q64.size() > 0)
          void'(q64.pop_front());
        if (b64.in_valid && b64.in_ready) begin
          m     = ref_imm(b64.instr, b64.ImmSrc);
          e.imm = m;
          e.tgt = b64.pc + m;
          e.err = (b64.ImmSrc == 3'b111);
          q64.push_back(e);
        end
      end
    end
  end

  // Single entry into an empty RV32 pipe, literal result
  task automatic one32(input string nm,
                       input logic [31:0] ins,
                       input logic [2:0] src,
                       input logic [31:0] pc,
                       input logic [31:0] eimm,
                       input logic [31:0] etgt,
                       input logic eerr);
    b32.instr     = ins;
    b32.ImmSrc    = src;
    b32.pc        = pc;
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_rdy"}, 64'(b32.in_ready), 64'd1);
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
    for (int k = 0; k < D - 1; k++) begin
      @(negedge clk);
      chk({nm, "_early"}, 64'(b32.out_valid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({nm, "_v"}, 64'(b32.out_valid), 64'd1);
    chk({nm, "_imm"}, 64'(b32.ImmOp), 64'(eimm));
    chk({nm, "_tgt"}, 64'(b32.target), 64'(etgt));
    chk({nm, "_err"}, 64'(b32.imm_err), 64'(eerr));
    @(posedge clk);
    #1;
  endtask

  task automatic one64(input string nm,
                       input logic [31:0] ins,
                       input logic [2:0] src,
                       input logic [63:0] pc,
                       input logic [63:0] eimm,
                       input logic [63:0] etgt);
    b64.instr    = ins;
    b64.ImmSrc   = src;
    b64.pc       = pc;
    b64.in_valid = 1'b1;
    @(posedge clk);
    #1 b64.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_v"}, 64'(b64.out_valid), 64'd1);
    chk({nm, "_imm"}, b64.ImmOp, eimm);
    chk({nm, "_tgt"}, b64.target, etgt);
    @(posedge clk);
    #1;
  endtask

  task automatic put32(input logic [31:0] ins,
                       input logic [31:0] pc);
    b32.instr    = ins;
    b32.ImmSrc   = 3'b000;
    b32.pc       = pc;
    b32.in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    b32.flush = 1'b0; b32.out_ready = 1'b1;
    b64.flush = 1'b0; b64.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.instr = '0;
    b64.ImmSrc = '0; b64.pc = '0;
    put32(32'hFFF00093, 32'h0);
    #2;
    chk("rst_inrdy", 64'(b32.in_ready), 64'd1);
    chk("rst_ov", 64'(b32.out_valid), 64'd0);
    chk("rst_imm", 64'(b32.ImmOp), 64'd0);
    chk("rst_tgt", 64'(b32.target), 64'd0);
    chk("rst_err", 64'(b32.imm_err), 64'd0);
    chk("rst_ov64", 64'(b64.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 b32.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_nocap", 64'(b32.out_valid), 64'd0);
    @(posedge clk);
    #1;

    one32("i", 32'hFFF00093, 3'b000, 32'h0,
          32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    one32("b", 32'hFE000EE3, 3'b010, 32'h100,
          32'hFFFFFFFC, 32'h000000FC, 1'b0);
    one32("s", 32'hFE112E23, 3'b001, 32'h40,
          32'hFFFFFFFC, 32'h0000003C, 1'b0);
    one32("u", 32'h123450B7, 3'b100, 32'h10,
          32'h12345000, 32'h12345010, 1'b0);
    one32("j", 32'hFFDFF06F, 3'b101, 32'h0,
          32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0);
    one32("wrap", 32'h02000093, 3'b000, 32'hFFFFFFF0,
          32'h00000020, 32'h00000010, 1'b0);
    one32("z", 32'h000FD073, 3'b110, 32'h4,
          32'h0000001F, 32'h00000023, 1'b0);
    one32("r", 32'hFFFFFFFF, 3'b011, 32'h88,
          32'h0, 32'h88, 1'b0);
    one32("ill", 32'hFFF00093, 3'b111, 32'h2000,
          32'h0, 32'h2000, 1'b1);

    one64("u64", 32'h800000B7, 3'b100, 64'h1000,
          64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000);
    one64("j64", 32'hFFDFF06F, 3'b101, 64'h0,
          64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    one64("z64", 32'h000FD073, 3'b110, 64'h8,
          64'h1F, 64'h27);

    // Backpressure: three offered, two held
    b32.out_ready = 1'b0;
    put32(32'h00100093, 32'h0);
    @(posedge clk);
    #1 put32(32'h00200093, 32'h0);
    @(posedge clk);
    #1 put32(32'h00300093, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_inrdy", 64'(b32.in_ready), 64'd0);
      chk("bp_frozen", 64'(b32.ImmOp), 64'd1);
      @(posedge clk);
    end
    #1 b32.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_o1v", 64'(b32.out_valid), 64'd1);
    chk("bp_o1", 64'(b32.ImmOp), 64'd1);
    chk("bp_inrdy1", 64'(b32.in_ready), 64'd1);
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_o2v", 64'(b32.out_valid), 64'd1);
    chk("bp_o2", 64'(b32.ImmOp), 64'd2);
    @(posedge clk);
    @(negedge clk);
    chk("bp_o3v", 64'(b32.out_valid), 64'd1);
    chk("bp_o3", 64'(b32.ImmOp), 64'd3);
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty", 64'(b32.out_valid), 64'd0);
    @(posedge clk);

    // Flush a full pipe with a new entry offered
    #1 b32.out_ready = 1'b0;
    put32(32'h00500093, 32'h0);
    @(posedge clk);
    #1 put32(32'h00600093, 32'h0);
    @(posedge clk);
    #1 put32(32'h00700093, 32'h0);
    b32.flush = 1'b1;
    @(negedge clk);
    chk("fl_inrdy", 64'(b32.in_ready), 64'd0);
    @(posedge clk);
    #1 b32.flush = 1'b0;
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fl_gone", 64'(b32.out_valid), 64'd0);
      @(posedge clk);
    end

    // Asynchronous reset with two entries in flight
    #1 put32(32'h00800093, 32'h300);
    @(posedge clk);
    #1 put32(32'h00900093, 32'h300);
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
    chk("ar_pre", 64'(b32.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov", 64'(b32.out_valid), 64'd0);
    chk("ar_imm", 64'(b32.ImmOp), 64'd0);
    chk("ar_tgt", 64'(b32.target), 64'd0);
    chk("ar_err", 64'(b32.imm_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    one32("fresh", 32'h00A00093, 3'b000, 32'h10,
          32'h0000000A, 32'h0000001A, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It extracts and sign-extends the RISC-V immediate selected by `ImmSrc` to `Width` bits, adds a Z-type (CSR zimm) mode and an illegal-selector flag, and computes the PC-relative target `pc + ImmOp`. Results pass through `Depth` elastic register stages with valid/ready handshakes, stall and flush, sitting between fetch/decode and the execute-stage operand muxes.

## Interface
- `Width`, 32: datapath width. Legal values are 32 (RV32) or 64 (RV64). Sign extension is always from `instr[31]`.
- `Depth`, 2: number of register stages, 1..4. This equals the latency in cycles.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `flush`  in  1: synchronous kill of every in-flight entry.
- `in_valid`  in  1: input entry present.
- `in_ready`  out  1: stage 0 can accept an entry.
- `instr`  in  32: instruction word.
- `ImmSrc`  in  3: immediate format selector.
- `pc`  in  Width: PC of `instr`.
- `out_valid`  out  1: output entry present.
- `out_ready`  in  1: consumer accepts the output entry.
- `ImmOp`  out  Width: extended immediate.
- `target`  out  Width: `pc + ImmOp`, modulo 2^Width.
- `imm_err`  out  1: entry had `ImmSrc` = 111.

## Operation
- Immediate decode is combinational on `instr`, then registered into stage 0. Let s = `instr[31]`.
  - 000, I-type: sext(`instr[31:20]`).
  - 001, S-type: sext({`instr[31:25]`,`instr[11:7]`}).
  - 010, B-type: sext({`instr[31]`,`instr[7]`,`instr[30:25]`,`instr[11:8]`,0}).
  - 011, R-type: 0.
  - 100, U-type: sext({`instr[31:12]`,12'b0}). Bits 63:32 take s when `Width` = 64.
  - 101, J-type: sext({`instr[31]`,`instr[19:12]`,`instr[20]`,`instr[30:21]`,0}).
  - 110, Z-type: zero-extend `instr[19:15]`.
  - 111, illegal: `ImmOp` = 0 and `imm_err` = 1.
- `target` = `pc` + `ImmOp` for every mode, truncated to `Width` (wraps, no carry out). The consumer ignores `target` where it is not meaningful.
- Pipeline: each stage i has `v[i]` and data registers (`ImmOp`, `target`, `imm_err`).
  - `rdy[Depth-1]` = `!v[Depth-1]` || `out_ready`.
  - `rdy[i]` = `!v[i]` || `rdy[i+1]`.
  - `in_ready` = `rdy[0]` && `!flush`.
- Transfer into stage i occurs when its upstream is valid and `rdy[i]` = 1. Data registers load only on transfer and hold while stalled.
- `out_valid` = `v[Depth-1]`. The outputs are the last-stage registers.
- Order is preserved. There is no reordering and no dropping except by flush.
- `flush`: all `v[i]` clear at the next edge. No input is accepted that cycle. Data registers keep their values but are don't-care. The output handshake that cycle is void.
- Simultaneous `out_ready` and upstream transfer into a full last stage is legal. Full throughput is one entry per cycle.

## Timing
- Latency: an entry accepted at edge N is visible with `out_valid` = 1 after edge N+`Depth`-1, i.e. `Depth` cycles after presentation. Pipe empty, no stall.
- Reset values: all `v[i]` = 0, `out_valid` = 0, `ImmOp` = 0, `target` = 0, `imm_err` = 0.
  - `in_ready` = 1 during reset (`flush` = 0) but no entry is captured.
  - Reset asserted mid-operation discards all entries immediately, without waiting for an edge.
- Capacity is `Depth` entries. With `out_ready` held 0, `in_ready` falls after `Depth` accepts. Outputs stay stable while `out_valid` && `!out_ready`.
- `in_ready` depends combinationally on `out_ready` and `flush`. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- I/B decode, `Width` = 32, `Depth` = 2:
  - `instr` = 0xFFF00093, `ImmSrc` = 000 -> two cycles later `ImmOp` = 0xFFFFFFFF, `imm_err` = 0.
  - `instr` = 0xFE000EE3, `ImmSrc` = 010, `pc` = 0x100 -> `ImmOp` = 0xFFFFFFFC, `target` = 0x000000FC.
- U/J and wrap:
  - `instr` = 0x123450B7, `ImmSrc` = 100 -> `ImmOp` = 0x12345000.
  - `instr` = 0xFFDFF06F, `ImmSrc` = 101, `pc` = 0 -> `ImmOp` = 0xFFFFFFFC, `target` = 0xFFFFFFFC.
  - With `Width` = 64: `instr` = 0x800000B7, `ImmSrc` = 100 -> `ImmOp` = 0xFFFFFFFF80000000.
- Z/illegal:
  - `instr` = 0x000FD073 (rs1 = 31), `ImmSrc` = 110 -> `ImmOp` = 0x1F.
  - `ImmSrc` = 111 -> `ImmOp` = 0, `imm_err` = 1, `target` = `pc`.
- Backpressure, `Depth` = 2: hold `out_ready` = 0 and offer 3 entries -> 2 accepted, `in_ready` = 0, outputs frozen on entry 1. Raise `out_ready` -> entries 1, 2, 3 emerge in order on consecutive cycles.
- Flush and reset:
  - Pipe full, assert `flush` one cycle -> `out_valid` = 0 next cycle and no stale entry appears later.
  - Assert `rst` mid-stream between edges -> `out_valid` and all outputs drop to 0 immediately.
  - After release, a fresh entry completes in `Depth` cycles.
